// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 multi-cycle multiply/divide unit producing the 64-bit HI/LO value
// Shift-add multiply and restoring divide share one 64-bit accumulator and a 32-bit operand register.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] hilo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] opnd;      // multiplicand for MUL, divisor for DIV
  logic [63:0] acc;       // MUL: {partial, multiplier}; DIV: {rem, quot}
  logic        neg_q;
  logic        neg_r;

  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        last;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] acc_nxt;
  logic [63:0] result;

  assign busy      = (state != IDLE);
  assign last      = (cnt == 6'd31);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign mag_b     = (is_signed && b[31]) ? (32'd0 - b) : b;

  always_comb begin
    state_nxt = state;
    mul_sum   = '0;
    div_sh    = '0;
    div_diff  = '0;
    acc_nxt   = acc;
    result    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT || op == OP_MULTU) state_nxt = MUL;
          else if (op == OP_DIV || op == OP_DIVU) state_nxt = DIV;
        end
      end
      MUL: begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        acc_nxt = {mul_sum, acc[31:1]};
        result  = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
        if (last) state_nxt = IDLE;
      end
      DIV: begin
        div_sh   = {acc[63:32], acc[31]};
        div_diff = div_sh - {1'b0, opnd};
        // No borrow out of the 33-bit difference means rem >= divisor
        if (!div_diff[32]) acc_nxt = {div_diff[31:0], acc[30:0], 1'b1};
        else               acc_nxt = {div_sh[31:0], acc[30:0], 1'b0};
        // A zero divisor leaves the quotient all ones; the remainder still
        // gets sign-restored so HI reproduces the original dividend.
        result[63:32] = neg_r ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
        result[31:0]  = (neg_q && (opnd != 32'd0)) ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hilo  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opnd  <= mag_a;
                acc   <= {32'd0, mag_b};
                neg_q <= is_signed && (a[31] ^ b[31]);
                neg_r <= is_signed && a[31];
                cnt   <= '0;
              end
              OP_DIV, OP_DIVU: begin
                opnd  <= mag_b;
                acc   <= {32'd0, mag_a};
                neg_q <= is_signed && (a[31] ^ b[31]);
                neg_r <= is_signed && a[31];
                cnt   <= '0;
              end
              OP_MTHI: hilo[63:32] <= a;
              OP_MTLO: hilo[31:0]  <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          acc <= acc_nxt;
          if (cnt != 6'h3F) cnt <= cnt + 6'd1;
          if (last) begin
            hilo <= result;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit that produces the 64-bit HI/LO value consumed by the register file's HI/LO write port. It sits beside the ALU in the execute stage. It accepts one operation at a time through a start/busy handshake, iterates radix-2 for 32 cycles, and holds the HI/LO result on a registered 64-bit bus. MTHI/MTLO complete in one cycle.

## Interface
- No parameters; widths fixed at 32-bit operands, 64-bit result.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request; accepted only on an edge where start=1 and busy=0
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- a  input  32  rs operand: multiplicand/dividend, or MTHI/MTLO data
- b  input  32  rt operand: multiplier/divisor
- busy  output  1  iteration in progress; the stage stalls any HI/LO access while busy=1
- done  output  1  one-cycle pulse in the cycle after the result lands
- hilo  output  64  registered {HI, LO}; drives the register file's 64-bit HI/LO write data

## Operation
- Reset (rst=0 at an edge): hilo=0, busy=0, done=0, iteration counter=0, operand registers=0. Reset overrides everything, including an in-flight operation, which is discarded.
- States: IDLE, MUL, DIV. After reset the unit is in IDLE.
- IDLE with an accepted start:
  - op 0-3: latch the magnitudes of a and b (signed ops take two's-complement absolute value; unsigned ops take them unchanged). Latch the result signs: quotient/product sign = sa^sb; remainder sign = sa. Clear the counter, go to MUL or DIV, busy=1.
  - op 4: hilo[63:32]<=a. op 5: hilo[31:0]<=a. Stay in IDLE; busy stays 0; done stays 0.
  - op 6/7: no effect.
- start while busy=1 is ignored for every op, including MTHI/MTLO; hilo is not disturbed.
- MUL: shift-add. Each cycle, if multiplier bit0=1, add the multiplicand to the upper 33 bits of the 64-bit accumulator, then shift right 1. Runs 32 iterations. The unsigned 64-bit product is negated if the sign is negative.
- DIV: restoring. Each cycle, shift {rem, quot} left 1. If rem >= divisor, subtract the divisor and set quot bit0. Runs 32 iterations. Negate the quotient if sa^sb; negate the remainder if sa.
- Results: LO = product[31:0] or quotient; HI = product[63:32] or remainder.
- Divide by zero: no trap. The unit runs the full 32 cycles and delivers LO=32'hFFFF_FFFF and HI=a, for both DIV and DIVU (sign correction is skipped when b=0).
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- hilo changes only on reset, on MTHI/MTLO, or on operation completion. Between these events it holds its value.

## Timing
- E0 is the accepting edge. Iterations occur at edges E1..E32.
- At E32: hilo is updated, busy returns to 0, done becomes 1, state returns to IDLE.
- At E33: done returns to 0.
- busy is high for exactly 32 cycles. Result latency is 32 cycles after acceptance.
- A new start may be accepted at E33, where busy=0 is sampled. The earliest back-to-back operations are therefore 33 edges apart.
- MTHI/MTLO: hilo is updated at E0, visible the following cycle.
- The counter is 6 bits and saturates; it never wraps during an operation.

## Test plan
- Reset: hold rst=0 for 2 edges with start=1 and op=0. Required: hilo=0, busy=0, done=0. Then release rst, pulse MTLO with a=0x1234 and MTHI with a=0xABCD. Required: hilo=0x0000ABCD_00001234.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF. Required: busy high for 32 cycles, done pulses once, hilo=0xFFFF_FFFE_0000_0001. Also run MULT a=-3, b=5. Required: hilo=0xFFFF_FFFF_FFFF_FFF1.
- DIV a=-7, b=2. Required: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Also run DIVU a=100, b=7. Required: LO=14, HI=2.
- DIVU a=0x55, b=0. Required: after 32 cycles, LO=0xFFFF_FFFF, HI=0x55. Also run DIV 0x8000_0000 / -1. Required: hilo=0x0000_0000_8000_0000.
- Start MULTU 3*4, then pulse MTHI a=0xDEAD and a DIVU at cycle 10 while busy. Required: both ignored; final hilo=0x0_0000_000C; done occurs exactly once.
- Start DIV, assert rst=0 at cycle 15. Required: busy=0 and hilo=0 on the next cycle, and no done pulse. A fresh MULTU 2*3 is then accepted and gives hilo=6.
